// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing, framebuffer geometry and colour constants
package vga_pkg;

  localparam int VGA_AW         = 15;
  localparam int VGA_DW         = 3;
  localparam int VGA_CW         = 10;

  localparam int FB_W           = 160;
  localparam int FB_H           = 120;
  localparam int FB_SCALE_LOG2  = 2;

  localparam int H_ACTIVE       = 640;
  localparam int H_FP           = 16;
  localparam int H_SYNC         = 96;
  localparam int H_BP           = 48;
  localparam int H_TOTAL        = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE       = 480;
  localparam int V_FP           = 10;
  localparam int V_SYNC         = 2;
  localparam int V_BP           = 33;
  localparam int V_TOTAL        = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

endpackage

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - h/v raster counters with raw sync, active flag and vblank tick
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP
) (
  input  logic              clk,
  input  logic              rst,
  output logic [VGA_CW-1:0] h,
  output logic [VGA_CW-1:0] v,
  output logic              active,
  output logic              hs_raw,
  output logic              vs_raw,
  output logic              vblank_tick
);

  localparam int HT = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
  localparam int VT = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;

  localparam logic [VGA_CW-1:0] H_LAST     = VGA_CW'(HT - 1);
  localparam logic [VGA_CW-1:0] V_LAST     = VGA_CW'(VT - 1);
  localparam logic [VGA_CW-1:0] H_ACT      = VGA_CW'(P_H_ACTIVE);
  localparam logic [VGA_CW-1:0] V_ACT      = VGA_CW'(P_V_ACTIVE);
  localparam logic [VGA_CW-1:0] HS_START   = VGA_CW'(P_H_ACTIVE + P_H_FP);
  localparam logic [VGA_CW-1:0] HS_END     = VGA_CW'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
  localparam logic [VGA_CW-1:0] VS_START   = VGA_CW'(P_V_ACTIVE + P_V_FP);
  localparam logic [VGA_CW-1:0] VS_END     = VGA_CW'(P_V_ACTIVE + P_V_FP + P_V_SYNC);

  logic [VGA_CW-1:0] h_q, h_d;
  logic [VGA_CW-1:0] v_q, v_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    h_d = h_q + VGA_CW'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VGA_CW'(1);
    end
  end

  // Decodes of the counter registers; the top adds the pipeline delay.
  assign h           = h_q;
  assign v           = v_q;
  assign active      = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw      = !((h_q >= HS_START) && (h_q < HS_END));
  assign vs_raw      = !((v_q >= VS_START) && (v_q < VS_END));
  assign vblank_tick = (h_q == '0) && (v_q == V_ACT);

endmodule

// File: rtl/vga_fb_reader.sv
// rtl/vga_fb_reader.sv - framebuffer scan-out: address generation, sync delay line, colour register
module vga_fb_reader
  import vga_pkg::*;
#(
  parameter int AW         = VGA_AW,
  parameter int DW         = VGA_DW,
  parameter int P_FB_W     = FB_W,
  parameter int SCALE_LOG2 = FB_SCALE_LOG2,
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_rd_addr,
  output logic          mem_rd_en,
  input  logic [DW-1:0] mem_rd_data,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic          vga_r,
  output logic          vga_g,
  output logic          vga_b,
  output logic          vblank_tick
);

  localparam int HT = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
  localparam int VT = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;

  localparam logic [VGA_CW-1:0] H_LAST     = VGA_CW'(HT - 1);
  localparam logic [VGA_CW-1:0] V_LAST     = VGA_CW'(VT - 1);
  localparam logic [VGA_CW-1:0] V_ACT_LAST = VGA_CW'(P_V_ACTIVE - 1);
  localparam logic [VGA_CW-1:0] ROW_MASK   = VGA_CW'((1 << SCALE_LOG2) - 1);
  localparam logic [AW-1:0]     ROW_STEP   = AW'(P_FB_W);

  logic [VGA_CW-1:0] h, v;
  logic              active, hs_raw, vs_raw;

  vga_sync_gen #(
    .P_H_ACTIVE (P_H_ACTIVE),
    .P_H_FP     (P_H_FP),
    .P_H_SYNC   (P_H_SYNC),
    .P_H_BP     (P_H_BP),
    .P_V_ACTIVE (P_V_ACTIVE),
    .P_V_FP     (P_V_FP),
    .P_V_SYNC   (P_V_SYNC),
    .P_V_BP     (P_V_BP)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .h           (h),
    .v           (v),
    .active      (active),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .vblank_tick (vblank_tick)
  );

  logic [AW-1:0] row_base_q, row_base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_en_q, rd_en_d;
  logic          act2_q, act2_d;
  logic [2:0]    hs_q, hs_d;
  logic [2:0]    vs_q, vs_d;
  logic [DW-1:0] rgb_q, rgb_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_base_q <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      act2_q     <= 1'b0;
      hs_q       <= 3'b111;
      vs_q       <= 3'b111;
      rgb_q      <= '0;
    end else begin
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      act2_q     <= act2_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      rgb_q      <= rgb_d;
    end
  end

  // row_base steps one framebuffer row after every SCALE lines, avoiding a v*FB_W multiply.
  always_comb begin
    row_base_d = row_base_q;
    if (h == H_LAST) begin
      if (v == V_LAST) begin
        row_base_d = '0;
      end else if (((v & ROW_MASK) == ROW_MASK) && (v < V_ACT_LAST)) begin
        row_base_d = row_base_q + ROW_STEP;
      end
    end
  end

  always_comb begin
    addr_d  = addr_q;
    rd_en_d = active;
    if (active) begin
      addr_d = row_base_q + AW'(h >> SCALE_LOG2);
    end
  end

  // Stage N+2 active flag qualifies the RAM data arriving in the same cycle.
  always_comb begin
    act2_d = rd_en_q;
    hs_d   = {hs_q[1:0], hs_raw};
    vs_d   = {vs_q[1:0], vs_raw};
    rgb_d  = act2_q ? mem_rd_data : DW'(COLOUR_BLACK);
  end

  assign mem_rd_addr = addr_q;
  assign mem_rd_en   = rd_en_q;
  assign vga_hsync   = hs_q[2];
  assign vga_vsync   = vs_q[2];
  assign vga_r       = rgb_q[2];
  assign vga_g       = rgb_q[1];
  assign vga_b       = rgb_q[0];

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb/tb_vga_fb_reader.sv - self-checking bench for vga_fb_reader on a reduced raster
module tb_vga_fb_reader;

  localparam int HA = 64, HF = 8, HS = 12, HB = 8;
  localparam int VA = 32, VF = 3, VS = 2, VB = 4;
  localparam int FBW = 16, FBH = 8;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] mem_rd_addr;
  logic        mem_rd_en;
  logic [2:0]  mem_rd_data = 3'b000;
  logic        vga_hsync, vga_vsync, vga_r, vga_g, vga_b, vblank_tick;

  vga_fb_reader #(
    .AW(15), .DW(3), .P_FB_W(FBW), .SCALE_LOG2(2),
    .P_H_ACTIVE(HA), .P_H_FP(HF), .P_H_SYNC(HS), .P_H_BP(HB),
    .P_V_ACTIVE(VA), .P_V_FP(VF), .P_V_SYNC(VS), .P_V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .mem_rd_addr(mem_rd_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vblank_tick(vblank_tick)
  );

  always #20 clk = ~clk;

  logic [2:0] ram [0:FBW*FBH-1];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;
  int phase    = 0;
  bit started  = 0;
  bit painted  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (k=%0d phase=%0d)", name, act, exp, k, phase);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) k <= 0;
    else      k <= k + 1;
  end

  function automatic bit in_active(input int x, input int y);
    return (x < HA) && (y < VA);
  endfunction

  function automatic int fb_addr(input int x, input int y);
    return (y / 4) * FBW + (x / 4);
  endfunction

  // Model: counters after k clocks sit at raster position k; address is one clock later, pins three.
  int exp_addr = 0;
  int max_addr = 0;
  always @(negedge clk) begin
    int cx, cy, px, py, qx, qy, e_en, e_hs, e_vs, e_rgb;
    if (started) begin
      if (!rst) begin
        exp_addr = 0;
        chk("rst_hsync", vga_hsync, 1);
        chk("rst_vsync", vga_vsync, 1);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_rd_addr, 0);
        chk("rst_tick", vblank_tick, 0);
      end else begin
        cx = k % HT; cy = (k / HT) % VT;
        chk("vblank_tick", vblank_tick, (cx == 0 && cy == VA) ? 1 : 0);
        e_en = 0;
        if (k >= 1) begin
          px = (k - 1) % HT; py = ((k - 1) / HT) % VT;
          if (in_active(px, py)) begin
            e_en = 1;
            exp_addr = fb_addr(px, py);
          end
        end
        chk("rd_en", mem_rd_en, e_en);
        chk("rd_addr", mem_rd_addr, exp_addr);
        e_hs = 1; e_vs = 1; e_rgb = 0;
        if (k >= 3) begin
          qx = (k - 3) % HT; qy = ((k - 3) / HT) % VT;
          e_hs = (qx >= HA + HF && qx < HA + HF + HS) ? 0 : 1;
          e_vs = (qy >= VA + VF && qy < VA + VF + VS) ? 0 : 1;
          if (in_active(qx, qy)) e_rgb = ram[fb_addr(qx, qy)];
        end
        chk("hsync", vga_hsync, e_hs);
        chk("vsync", vga_vsync, e_vs);
        chk("rgb", {vga_r, vga_g, vga_b}, e_rgb);

        if (phase == 0) begin
          if (mem_rd_en && mem_rd_addr > max_addr) max_addr = mem_rd_addr;
          if (k == 3)                    chk("lit_px0_0", {vga_r, vga_g, vga_b}, 0);
          if (k == 7)                    chk("lit_px4_0", {vga_r, vga_g, vga_b}, 1);
          if (k == 63)                   chk("lit_px60_0", {vga_r, vga_g, vga_b}, 7);
          if (k == 67)                   chk("lit_blank64", {vga_r, vga_g, vga_b}, 0);
          if (k == 3 + 2*HT + 2)         chk("lit_px2_2_pre", {vga_r, vga_g, vga_b}, 0);
          if (k == 4*HT + 1)             chk("lit_row_base16", mem_rd_addr, 16);
          if (k == FR + 1)               chk("lit_row_base_wrap", mem_rd_addr, 0);
          if (k == FR + 3 + 4)           chk("lit_f1_px4_0", {vga_r, vga_g, vga_b}, 1);
          if (k == FR + 3 + 2*HT + 2)    chk("lit_f1_white2_2", {vga_r, vga_g, vga_b}, 7);
          if (k == FR + 3 + 3*HT + 3)    chk("lit_f1_white3_3", {vga_r, vga_g, vga_b}, 7);
          if (k == FR + 3 + 3*HT + 4)    chk("lit_f1_px4_3", {vga_r, vga_g, vga_b}, 1);
          if (k == FR + 3 + 4*HT)        chk("lit_f1_px0_4", {vga_r, vga_g, vga_b}, 0);
          if (vblank_tick) begin
            chk("addr_max", max_addr, FBH*FBW - 1);
            max_addr = 0;
            if (!painted) begin
              ram[0] = 3'b111;
              painted = 1;
            end
          end
        end
      end
    end
  end

  int hs_low = 0, vs_low = 0, last_tick = -1;
  bit hs_prev = 1, vs_prev = 1;
  always @(negedge clk) begin
    if (!rst) begin
      hs_low = 0; vs_low = 0; last_tick = -1; hs_prev = 1; vs_prev = 1;
    end else if (started) begin
      if (!vga_hsync) hs_low++;
      else if (!hs_prev) begin chk("hsync_width", hs_low, HS); hs_low = 0; end
      if (!vga_vsync) vs_low++;
      else if (!vs_prev) begin chk("vsync_width", vs_low, VS*HT); vs_low = 0; end
      hs_prev = vga_hsync; vs_prev = vga_vsync;
      if (vblank_tick) begin
        if (last_tick >= 0) chk("tick_spacing", k - last_tick, FR);
        last_tick = k;
      end
    end
  end

  task automatic wait_k(input int target);
    int guard = 0;
    while (k < target && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    if (k < target) chk("wait_timeout", k, target);
  endtask

  initial begin
    int n;
    for (int i = 0; i < FBW*FBH; i++) ram[i] = i[2:0];
    #5 rst = 1'b0;
    started = 1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_k(3*FR + 20*HT + 50);
    #2 rst = 1'b0;
    #1;
    chk("async_hsync", vga_hsync, 1);
    chk("async_vsync", vga_vsync, 1);
    chk("async_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("async_rd_en", mem_rd_en, 0);
    chk("async_addr", mem_rd_addr, 0);
    phase = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (!vga_hsync) break;
    end
    chk("first_hsync_fall", n, HA + HF + 3);
    wait_k(FR + 200);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Scan-out engine for the game framebuffer. Generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock. Reads the 160x120 3-bit framebuffer through the read port of the dual-port pixel RAM, replicates each stored pixel 4x4, and drives RGB111 plus sync. It is the read-side counterpart of the game FSM, which writes the same RAM through `mem_px_addr`/`mem_px_data`/`px_wr`. It also issues a vertical-blank tick so the writer can update without tearing.

## Interface
- AW, 15, framebuffer address width
- DW, 3, pixel width; bit 2 = R, bit 1 = G, bit 0 = B
- FB_W, 160, framebuffer columns
- FB_H, 120, framebuffer rows
- SCALE_LOG2, 2, log2 of pixel replication factor in both axes
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixel clocks; total 800
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines; total 525
- clk, in, 1, 25 MHz pixel clock; the only clock
- rst, in, 1, asynchronous active-low reset
- mem_rd_addr, out, AW, framebuffer read address
- mem_rd_en, out, 1, read enable; high only for active-region fetches
- mem_rd_data, in, DW, RAM read data; synchronous read, valid one cycle after address
- vga_hsync, out, 1, horizontal sync, active-low
- vga_vsync, out, 1, vertical sync, active-low
- vga_r / vga_g / vga_b, out, 1 each, colour outputs
- vblank_tick, out, 1, one-cycle pulse at the start of vertical blanking

## Operation
- Counters `h` (0..799) and `v` (0..524):
  - `h` increments every clock.
  - On h=799, `h` wraps to 0 and `v` increments; on v=524, `v` wraps to 0.
- Active region is h<640 and v<480.
- Sync:
  - hsync is low for 656 ≤ h ≤ 751.
  - vsync is low for 490 ≤ v ≤ 491.
- Address generation uses no multiplier:
  - `row_base` register, AW bits. It is 0 at v=0.
  - At h=799 with v[1:0]=3 and v<479, it adds FB_W.
  - At h=799, v=524, it loads 0.
  - mem_rd_addr = row_base + h[9:2], registered.
- mem_rd_en is the registered active flag. Outside the active region, mem_rd_addr holds its last value.
- Colour:
  - In the active region, {vga_r,vga_g,vga_b} = mem_rd_data, registered.
  - Outside the active region, colour is forced to 000.
- vblank_tick is high for one clock when the counters equal (h=0, v=480), before pipeline delay.
- Reset, asynchronous:
  - h, v, row_base, mem_rd_addr → 0.
  - mem_rd_en, vga_r/g/b, vblank_tick → 0.
  - vga_hsync, vga_vsync → 1.
  - All pipeline stages cleared.
- Reset deasserted mid-frame restarts cleanly at (0,0). No partial frame recovery is required.
- The RAM is never written by this block. Read/write collisions are resolved by the RAM; this block tolerates old or new data.

## Timing
- Pipeline from counters to pins is 3 clocks:
  - N: counters
  - N+1: mem_rd_addr/mem_rd_en
  - N+2: RAM data
  - N+3: RGB registered
- hsync, vsync and the active flag pass through a 3-stage delay so they align with RGB.
- The first visible pixel (h=0, v=0) appears on the pins 3 clocks after the counters reach (0,0).
- Line period is 800 clocks; frame period is 420 000 clocks (59.52 Hz at 25 MHz).
- vblank_tick is not delayed: it leads the pin-level blank by 3 clocks. The writer may use all 45 blank lines (36 000 clocks).
- No handshake with the RAM: the read is fire-and-forget, with fixed 1-cycle latency.

## Structure
- Shared package `vga_pkg`:
  - H_*/V_* timing constants
  - totals H_TOTAL=800, V_TOTAL=525
  - FB_W, FB_H
  - colour constants (black 3'b000, white 3'b111) shared with the game FSM
- Sub-module `vga_sync_gen`:
  - contains the h/v counters, raw sync, active flag and vblank_tick
  - outputs h, v, active, hs_raw, vs_raw
- Top `vga_fb_reader`: address generator, delay line and colour register.

## Test plan
- Reset, then free-run 2 frames with a behavioural 1-cycle RAM:
  - hsync low 96 clocks every 800.
  - vsync low exactly 1600 clocks every 420 000.
  - Sync high during reset.
- RAM preloaded with addr[2:0] as data, check line 0:
  - Pins show each value for 4 consecutive pixels.
  - Pixel x=4 shows 1; pixel x=636 shows 159 mod 8 = 7.
  - RGB is 000 for h 640..799.
- Address check:
  - At v=3→4, row_base goes 0→160.
  - At v=479, mem_rd_addr max = 119*160+159 = 19199.
  - After the frame wrap, row_base = 0.
- vblank_tick:
  - Exactly one pulse per frame, at counter (0,480).
  - Spacing is 420 000 clocks.
  - It is never high during the active region.
- rst asserted at (h=300, v=200) for 5 clocks:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the first hsync falling edge occurs 656+3 clocks later.
- Writer concurrency:
  - The write side paints framebuffer address 0 with 3'b111 during vblank.
  - The next frame shows white at pins for x 0..3, y 0..3 only.
